mem_datos_sinc: RTL
===================

// Module: mem_datos_sinc
// PURPOSE
// - Parametrised, clocked data memory for the single-cycle/pipelined CPU datapath.
// - Byte-addressed with byte, half and word loads/stores and sign/zero extension of loads.
// - Valid/ready request channel, registered response, misalignment/range error reporting.
// - Hardware zero-fill of the whole array after reset.
// PARAMETERS
// - DEPTH      256  number of 32-bit words; power of two, >= 4
// - ADDR_W     32   width of the byte address
// - INIT_ZERO  1    1 = run zero-fill sweep after reset; 0 = skip it (contents undefined)
// PORTS
// - clk           in   1       clock, all state on rising edge
// - rst_n         in   1       asynchronous active-low reset
// - req_valid     in   1       request present
// - req_ready     out  1       block accepts a request this cycle
// - req_we        in   1       1 = store, 0 = load
// - req_addr      in   ADDR_W  byte address
// - req_size      in   2       00 byte, 01 half, 10 word, 11 illegal
// - req_unsigned  in   1       load zero-extends when 1, sign-extends when 0
// - req_wdata     in   32      store data; value in low bits for byte/half
// - rsp_valid     out  1       one-cycle pulse, response for the accepted request
// - rsp_rdata     out  32      extended load data; 0 for stores and errors
// - rsp_err       out  1       request rejected; no memory side effect
// - init_done     out  1       zero-fill complete; stays high until next reset
// BEHAVIOUR
// - Reset (async assert, sync release): req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0,
//   init_done=0, FSM -> INIT (or RUN when INIT_ZERO=0), sweep counter=0.
// - In-flight responses are dropped on reset. Array contents are not reset asynchronously.
// - FSM INIT: writes word[cnt]=0 each cycle, cnt++.
//   - After DEPTH cycles -> RUN; init_done=1, req_ready=1 from the following cycle.
// - FSM RUN: req_ready=1 constantly; no backpressure on the response side.
// - Accept = req_valid & req_ready.
//   - Requests arriving while req_ready=0 are ignored; no response.
// - Latency: response exactly 1 cycle after accept; throughput 1 request/cycle.
// - Word index = req_addr[log2(DEPTH)+1:2]; lane = req_addr[1:0], little-endian.
// - Error when any of the following holds:
//   - req_size=11
//   - half with addr[0]=1
//   - word with addr[1:0]!=0
//   - addr >= 4*DEPTH
//   - On error: no write, rsp_err=1, rsp_rdata=0.
// - Store: at the accept edge, only the addressed lanes are written with req_wdata low bits.
//   - Other lanes are unchanged. rsp_rdata=0.
// - Load: word read at the accept edge, lane extracted, then extended per req_unsigned.
//   - Extension applies to byte and half only. Result is registered into rsp_rdata.
// - Store at edge N, load of the same word at edge N+1: returns the new data.
// - rsp_rdata/rsp_err hold their value when rsp_valid=0; they are only meaningful with rsp_valid.
// STRUCTURE
// - Package mem_pkg:
//   - size constants SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
//   - FSM state encoding ST_INIT, ST_RUN
// - Sub-module mem_lane_align (combinational):
//   - store path: byte-enable and lane-shifted write data
//   - load path: lane extract and sign/zero extension
//   - misalignment flag
// - Top: FSM, sweep counter, array, response registers.
// TESTING
// - Reset, DEPTH=256: req_ready=0 for 256 cycles, then init_done=1 and req_ready=1;
//   a load of any word returns 0.
// - SW 0x8000_00F0 @0x10; LB @0x10 -> 0xFFFF_FFF0; LBU @0x10 -> 0x0000_00F0;
//   LH @0x12 -> 0xFFFF_8000; LW @0x10 -> 0x8000_00F0.
// - SB 0xAA @0x21 over a word holding 0x1122_3344, then LW @0x20 -> 0x1122_AA44.
// - LW @0x02, LH @0x01, size=11, LW @4*DEPTH -> each rsp_err=1, rsp_rdata=0;
//   a following LW shows memory unchanged.
// - Back-to-back SW 0x1234_5678 @0x40 then LW @0x40 on the next cycle
//   -> rsp_valid on 2 consecutive cycles, second rsp_rdata=0x1234_5678.
// - Assert rst_n mid-stream with a load in flight -> rsp_valid=0 immediately,
//   no response after release, INIT sweep reruns.

Source files
------------

// File: rtl/mem_datos_sinc_pkg.sv
// Shared constants for the data memory: access-size encodings and FSM states.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_datos_sinc_if.sv
// Request/response channel between a CPU load/store unit and the data memory.
interface mem_datos_sinc_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              init_done;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );
endinterface

// File: rtl/mem_datos_sinc_lane_align.sv
// Byte-lane steering: store byte enables/replicated data, load extract and extend.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  st_lane_i,
    input  logic [1:0]  st_size_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    output logic        misalign_o,
    input  logic [31:0] ld_word_i,
    input  logic [1:0]  ld_lane_i,
    input  logic [1:0]  ld_size_i,
    input  logic        ld_unsigned_i,
    output logic [31:0] ld_data_o
);

    // Store path: data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        st_be_o    = 4'b0000;
        st_wdata_o = 32'h0;
        misalign_o = 1'b0;
        case (st_size_i)
            SZ_BYTE: begin
                st_be_o    = 4'b0001 << st_lane_i;
                st_wdata_o = {4{st_wdata_i[7:0]}};
            end
            SZ_HALF: begin
                st_be_o    = st_lane_i[1] ? 4'b1100 : 4'b0011;
                st_wdata_o = {2{st_wdata_i[15:0]}};
                misalign_o = st_lane_i[0];
            end
            SZ_WORD: begin
                st_be_o    = 4'b1111;
                st_wdata_o = st_wdata_i;
                misalign_o = (st_lane_i != 2'b00);
            end
            default: begin
                st_be_o    = 4'b0000;
            end
        endcase
    end

    // Load path: shift the addressed lane down to bit 0, then sign- or zero-extend.
    logic [31:0] ld_shift;
    always_comb begin
        ld_shift  = ld_word_i >> {ld_lane_i, 3'b000};
        ld_data_o = 32'h0;
        case (ld_size_i)
            SZ_BYTE: ld_data_o = ld_unsigned_i ? {24'h0, ld_shift[7:0]}
                                               : {{24{ld_shift[7]}}, ld_shift[7:0]};
            SZ_HALF: ld_data_o = ld_unsigned_i ? {16'h0, ld_shift[15:0]}
                                               : {{16{ld_shift[15]}}, ld_shift[15:0]};
            SZ_WORD: ld_data_o = ld_word_i;
            default: ld_data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_datos_sinc.sv
// Byte-addressed data memory with zero-fill after reset and one-cycle registered response.
module mem_datos_sinc
    import mem_pkg::*;
#(
    parameter int DEPTH     = 256,
    parameter int ADDR_W    = 32,
    parameter int INIT_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_datos_sinc_if.slave   bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam mem_state_e RST_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;

    mem_state_e        state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              init_we;
    logic              ready_q, done_q;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       rd_word_q;

    logic              rsp_valid_q, rsp_err_q, rsp_load_q, rsp_uns_q;
    logic [1:0]        rsp_lane_q, rsp_size_q;

    logic              accept, err, out_of_range, misalign;
    logic [IDX_W-1:0]  req_idx;
    logic [3:0]        st_be;
    logic [31:0]       st_wdata, ld_data;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;

    assign accept       = bus.req_valid & ready_q;
    assign req_idx      = bus.req_addr[IDX_W+1:2];
    assign out_of_range = (bus.req_addr >> (IDX_W + 2)) != '0;
    assign err          = (bus.req_size == SZ_ILL) | misalign | out_of_range;

    mem_lane_align u_align (
        .st_lane_i     (bus.req_addr[1:0]),
        .st_size_i     (bus.req_size),
        .st_wdata_i    (bus.req_wdata),
        .st_be_o       (st_be),
        .st_wdata_o    (st_wdata),
        .misalign_o    (misalign),
        .ld_word_i     (rd_word_q),
        .ld_lane_i     (rsp_lane_q),
        .ld_size_i     (rsp_size_q),
        .ld_unsigned_i (rsp_uns_q),
        .ld_data_o     (ld_data)
    );

    // FSM next state: INIT sweeps every word once, then RUN forever.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_we = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_we = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // FSM state, sweep counter and handshake flags; ready follows the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == ST_RUN);
            done_q  <= (state_d == ST_RUN);
        end
    end

    // Single write port shared by the zero-fill sweep and accepted stores.
    always_comb begin
        wr_en   = accept & bus.req_we & ~err;
        wr_idx  = req_idx;
        wr_be   = st_be;
        wr_data = st_wdata;
        if (init_we) begin
            wr_en   = 1'b1;
            wr_idx  = cnt_q;
            wr_be   = 4'b1111;
            wr_data = 32'h0;
        end
    end

    // Array with per-byte write enables and registered read; contents never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
        if (accept & ~bus.req_we) rd_word_q <= mem[req_idx];
    end

    // Response registers: pulse valid, hold error/lane info until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
            rsp_uns_q   <= 1'b0;
            rsp_lane_q  <= 2'b00;
            rsp_size_q  <= SZ_BYTE;
        end else begin
            rsp_valid_q <= accept;
            if (accept) begin
                rsp_err_q  <= err;
                rsp_load_q <= ~bus.req_we & ~err;
                rsp_uns_q  <= bus.req_unsigned;
                rsp_lane_q <= bus.req_addr[1:0];
                rsp_size_q <= bus.req_size;
            end
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.init_done = done_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_load_q ? ld_data : 32'h0;

endmodule
